// File: rtl/sr_pulse_driver.sv
// Pulse driver for an external gated SR latch: one command = PULSE_W drive cycles, GUARD_W quiet cycles, one done cycle.
// Optional completed-command counter on op_cnt is enabled by defining SR_DRV_COUNT_EN.
module sr_pulse_driver #(
  parameter int unsigned PULSE_W = 4,
  parameter int unsigned GUARD_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  output logic       req_ready,
  output logic       s,
  output logic       r,
  output logic       en,
  output logic       q_exp,
  output logic       busy,
  output logic       done,
  output logic [7:0] op_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_W - 1);
  localparam logic [7:0] GUARD_LAST = (GUARD_W == 0) ? 8'd0 : 8'(GUARD_W - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_s;
  logic       r_r;
  logic       r_en;
  logic       r_q;
  logic       r_busy;
  logic       r_done;

  logic       w_accept;
  logic       w_set;
  logic       w_clr;
  logic       w_en_cmd;
  logic       w_pulse_end;
  logic       w_finish;

  // Ready comes straight from the state register, masked so nothing looks acceptable during reset.
  assign req_ready = (r_state == IDLE) && !rst;
  assign w_accept  = req_valid && (r_state == IDLE);

  assign w_pulse_end = (r_state == PULSE) && (r_cnt == PULSE_LAST);
  assign w_finish    = (w_pulse_end && (GUARD_W == 0)) ||
                       ((r_state == GUARD) && (r_cnt == GUARD_LAST));

  // Toggle resolves to set or clear from the current expected latch value.
  always_comb begin
    w_set    = 1'b0;
    w_clr    = 1'b0;
    w_en_cmd = (req_op != 2'b00);
    case (req_op)
      2'b10:   w_set = 1'b1;
      2'b01:   w_clr = 1'b1;
      2'b11: begin
        w_set = !r_q;
        w_clr = r_q;
      end
      default: begin
        w_set = 1'b0;
        w_clr = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_en    <= 1'b0;
      r_q     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= PULSE;
            r_cnt   <= 8'd0;
            r_s     <= w_set;
            r_r     <= w_clr;
            r_en    <= w_en_cmd;
            r_q     <= w_set;
            r_busy  <= 1'b1;
          end
        end
        PULSE: begin
          if (w_pulse_end) begin
            r_s   <= 1'b0;
            r_r   <= 1'b0;
            r_cnt <= 8'd0;
            if (w_finish) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= GUARD;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        GUARD: begin
          if (w_finish) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign s     = r_s;
  assign r     = r_r;
  assign en    = r_en;
  assign q_exp = r_q;
  assign busy  = r_busy;
  assign done  = r_done;

`ifdef SR_DRV_COUNT_EN
  logic [7:0] r_op_cnt;

  // Counts on the same edge that raises done, so the done cycle already shows the new total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_cnt <= 8'd0;
    end else if (w_finish && (r_op_cnt != 8'hFF)) begin
      r_op_cnt <= r_op_cnt + 8'd1;
    end
  end

  assign op_cnt = r_op_cnt;
`else
  assign op_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Self-checking bench for sr_pulse_driver: directed checks on a PULSE_W=4/GUARD_W=2 instance,
// then randomized commands on a GUARD_W=0 instance against a queue-based reference model.
module tb_sr_pulse_driver;

   localparam int PwA = 4;
   localparam int GwA = 2;
   localparam int PwB = 4;
   localparam int GwB = 0;
   localparam int StressCmds = 1000;
   localparam int StressCycleLimit = 20000;

`ifdef SR_DRV_COUNT_EN
   localparam bit CountEn = 1'b1;
`else
   localparam bit CountEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic       aValid = 1'b0;
   logic [1:0] aOp = 2'b00;
   logic       aReady, aS, aR, aEn, aQ, aBusy, aDone;
   logic [7:0] aCnt;

   logic       bValid = 1'b0;
   logic [1:0] bOp = 2'b00;
   logic       bReady, bS, bR, bEn, bQ, bBusy, bDone;
   logic [7:0] bCnt;

   int testsRun = 0;
   int testsFailed = 0;
   logic [7:0] expCountA = 8'd0;

   typedef struct packed {
      logic s;
      logic r;
      logic en;
      logic q;
      logic busy;
      logic done;
   } entry_t;

   // Free-running clock shared by both instances.
   always #5 clk = ~clk;

   sr_pulse_driver #(.PULSE_W(PwA), .GUARD_W(GwA)) dutA (
      .clk(clk), .rst(rst), .req_valid(aValid), .req_op(aOp), .req_ready(aReady),
      .s(aS), .r(aR), .en(aEn), .q_exp(aQ), .busy(aBusy), .done(aDone), .op_cnt(aCnt)
   );

   sr_pulse_driver #(.PULSE_W(PwB), .GUARD_W(GwB)) dutB (
      .clk(clk), .rst(rst), .req_valid(bValid), .req_op(bOp), .req_ready(bReady),
      .s(bS), .r(bR), .en(bEn), .q_exp(bQ), .busy(bBusy), .done(bDone), .op_cnt(bCnt)
   );

   // Single comparison point: every check is counted here and mismatches are reported.
   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed %02h, expected %02h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] satInc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Bit order {s, r, en, q_exp, busy, done, req_ready}.
   task automatic expectA(input string tag, input logic es, input logic er, input logic een,
                          input logic eq, input logic ebusy, input logic edone, input logic eready);
      checkOutput(tag, {1'b0, aS, aR, aEn, aQ, aBusy, aDone, aReady},
                       {1'b0, es, er, een, eq, ebusy, edone, eready});
   endtask

   // Holds a reset pulse and checks that both the reset state and the first post-reset state are right.
   task automatic resetAll(input string tag);
      @(negedge clk);
      aValid = 1'b0;
      bValid = 1'b0;
      rst = 1'b1;
      #1;
      expectA({tag, "_inReset"}, 0, 0, 0, 0, 0, 0, 0);
      checkOutput({tag, "_cntInReset"}, aCnt, 8'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      expectA({tag, "_afterReset"}, 0, 0, 0, 0, 0, 0, 1);
      expCountA = 8'd0;
   endtask

   // Raises a request, holds it until ready, then drops it one step after the accepting edge.
   task automatic applyStimulus(input logic [1:0] op, input string tag);
      int waitCycles;
      waitCycles = 0;
      aOp = op;
      aValid = 1'b1;
      while (!aReady && waitCycles < 50) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput({tag, "_acceptWait"}, {7'b0, aReady}, 8'h01);
      @(posedge clk);
      #1;
      aValid = 1'b0;
      aOp = 2'($urandom);
   endtask

   // One full command on instance A, checking every cycle of pulse, guard and done.
   task automatic runCmd(input logic [1:0] op, input logic es, input logic er, input logic een,
                         input logic eq, input string tag);
      applyStimulus(op, tag);
      for (int i = 0; i < PwA; i++) begin
         @(negedge clk);
         expectA($sformatf("%s_pulse%0d", tag, i), es, er, een, eq, 1, 0, 0);
      end
      for (int i = 0; i < GwA; i++) begin
         @(negedge clk);
         expectA($sformatf("%s_guard%0d", tag, i), 0, 0, een, eq, 1, 0, 0);
      end
      @(negedge clk);
      expectA({tag, "_done"}, 0, 0, een, eq, 0, 1, 1);
      if (CountEn) expCountA = satInc(expCountA);
      checkOutput({tag, "_opCnt"}, aCnt, expCountA);
   endtask

   initial begin
      entry_t     model[$];
      entry_t     expE;
      logic       modelEn, modelQ, expReady, latch, readySeen, accepted;
      logic       ns, nr, nen, nq;
      logic [7:0] modelCnt;
      int         acceptedCmds, cycles, gap;

      $display("[TB] starting");

      // Directed: single set, then three toggles from a clean reset.
      resetAll("rst0");
      runCmd(2'b10, 1, 0, 1, 1, "set");
      resetAll("rst1");
      runCmd(2'b11, 1, 0, 1, 1, "tog1");
      runCmd(2'b11, 0, 1, 1, 0, "tog2");
      runCmd(2'b11, 1, 0, 1, 1, "tog3");
      checkOutput("togCount", aCnt, CountEn ? 8'd3 : 8'd0);

      // Directed: disable keeps en low while idle, a following clear restores it.
      runCmd(2'b10, 1, 0, 1, 1, "set2");
      runCmd(2'b00, 0, 0, 0, 0, "dis");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         expectA($sformatf("disIdle%0d", i), 0, 0, 0, 0, 0, 0, 1);
      end
      runCmd(2'b01, 0, 1, 1, 0, "clr");

      // Directed: request raised mid-pulse waits for the done cycle; its op must not leak in early.
      applyStimulus(2'b01, "busyClr");
      @(negedge clk);
      expectA("busyClr_pulse0", 0, 1, 1, 0, 1, 0, 0);
      @(negedge clk);
      aValid = 1'b1;
      aOp = 2'b10;
      expectA("busyClr_pulse1", 0, 1, 1, 0, 1, 0, 0);
      for (int i = 2; i < PwA; i++) begin
         @(negedge clk);
         expectA($sformatf("busyClr_pulse%0d", i), 0, 1, 1, 0, 1, 0, 0);
      end
      for (int i = 0; i < GwA; i++) begin
         @(negedge clk);
         expectA($sformatf("busyClr_guard%0d", i), 0, 0, 1, 0, 1, 0, 0);
      end
      @(negedge clk);
      expectA("busyClr_done", 0, 0, 1, 0, 0, 1, 1);
      @(posedge clk);
      #1;
      aValid = 1'b0;
      @(negedge clk);
      expectA("heldSet_pulse0", 1, 0, 1, 1, 1, 0, 0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      aValid = 1'b1;
      aOp = 2'b10;
      #1;
      expectA("midPulseReset", 0, 0, 0, 0, 0, 0, 0);
      checkOutput("midPulseResetCnt", aCnt, 8'd0);
      repeat (2) @(posedge clk);
      #1;
      expectA("noAcceptInReset", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      aValid = 1'b0;
      rst = 1'b0;
      #1;
      expectA("afterMidReset", 0, 0, 0, 0, 0, 0, 1);

      // Random stress on the GUARD_W=0 instance against the queue model and an SR-latch model.
      resetAll("rstStress");
      model.delete();
      modelEn = 1'b0;
      modelQ = 1'b0;
      modelCnt = 8'd0;
      latch = 1'b0;
      acceptedCmds = 0;
      cycles = 0;
      gap = $urandom_range(0, 3);
      while (acceptedCmds < StressCmds && cycles < StressCycleLimit) begin
         @(negedge clk);
         cycles++;
         if (model.size() != 0) begin
            expE = model[0];
            expReady = model[0].done;
         end else begin
            expE = '{s: 1'b0, r: 1'b0, en: modelEn, q: modelQ, busy: 1'b0, done: 1'b0};
            expReady = 1'b1;
         end
         checkOutput("stressVec", {1'b0, bS, bR, bEn, bQ, bBusy, bDone, bReady},
                                  {1'b0, expE.s, expE.r, expE.en, expE.q, expE.busy, expE.done, expReady});
         checkOutput("stressCnt", bCnt, CountEn ? modelCnt : 8'd0);
         checkOutput("stressSrExcl", {7'b0, bS & bR}, 8'h00);
         if (!bEn) latch = 1'b0;
         else if (bS) latch = 1'b1;
         else if (bR) latch = 1'b0;
         checkOutput("stressLatch", {7'b0, bQ}, {7'b0, latch});

         if (!bValid) begin
            if (gap == 0) begin
               bValid = 1'b1;
               bOp = 2'($urandom_range(0, 3));
            end else begin
               gap--;
               bOp = 2'($urandom);
            end
         end
         readySeen = bReady;

         @(posedge clk);
         accepted = bValid && expReady;
         if (model.size() != 0) void'(model.pop_front());
         if (accepted) begin
            case (bOp)
               2'b10:   begin ns = 1'b1;    nr = 1'b0;   nq = 1'b1;    end
               2'b01:   begin ns = 1'b0;    nr = 1'b1;   nq = 1'b0;    end
               2'b11:   begin ns = !modelQ; nr = modelQ; nq = !modelQ; end
               default: begin ns = 1'b0;    nr = 1'b0;   nq = 1'b0;    end
            endcase
            nen = (bOp != 2'b00);
            modelEn = nen;
            modelQ = nq;
            for (int i = 0; i < PwB; i++)
               model.push_back('{s: ns, r: nr, en: nen, q: nq, busy: 1'b1, done: 1'b0});
            for (int i = 0; i < GwB; i++)
               model.push_back('{s: 1'b0, r: 1'b0, en: nen, q: nq, busy: 1'b1, done: 1'b0});
            model.push_back('{s: 1'b0, r: 1'b0, en: nen, q: nq, busy: 1'b0, done: 1'b1});
         end
         if (model.size() != 0 && model[0].done) modelCnt = satInc(modelCnt);
         #1;
         if (bValid && readySeen) begin
            acceptedCmds++;
            bValid = 1'b0;
            gap = $urandom_range(0, 3);
         end
      end
      checkOutput("stressCompleted", {7'b0, acceptedCmds >= StressCmds}, 8'h01);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/sr_pulse_driver.md
SR_PULSE_DRIVER -- requirements
Module: sr_pulse_driver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter PULSE_W, default 4, SHALL set the number of cycles s, r or the en-low window is held; legal range 1..255.
REQ-003 Parameter GUARD_W, default 2, SHALL set the number of cycles with s=r=0 after each pulse; legal range 0..255.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req_valid  in  1  command request.
REQ-007 req_op  in  2  command: 00 disable, 01 clear, 10 set, 11 toggle.
REQ-008 req_ready  out  1  command accepted when req_valid and req_ready are both high at a rising edge.
REQ-009 s  out  1  latch set drive.
REQ-010 r  out  1  latch reset drive.
REQ-011 en  out  1  latch enable drive.
REQ-012 q_exp  out  1  expected latch output.
REQ-013 busy  out  1  high when the FSM is not IDLE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 op_cnt  out  8  count of completed commands (see Configuration).

Function
REQ-016 The FSM SHALL have three states, IDLE, PULSE and GUARD, and all outputs SHALL be registered.
REQ-017 req_ready SHALL equal (state==IDLE) and SHALL be low while rst is high.
REQ-018 On acceptance the FSM SHALL enter PULSE on the next cycle and stay there for exactly PULSE_W cycles.
REQ-019 PULSE drive per command:
- set: s=1, r=0, en=1.
- clear: s=0, r=1, en=1.
- toggle: acts as set if q_exp was 0, otherwise as clear.
- disable: s=0, r=0, en=0.
REQ-020 q_exp SHALL take its new value on the first PULSE cycle: 1 after set, 0 after clear or disable, inverted after toggle.
REQ-021 After PULSE the FSM SHALL enter GUARD for GUARD_W cycles with s=r=0. If GUARD_W=0, it SHALL go directly to IDLE.
REQ-022 en SHALL stay 1 after any set, clear or toggle until the next disable command or reset.
REQ-023 en SHALL stay 0 after a disable command until the next set, clear or toggle command is accepted.
REQ-024 done SHALL be high for exactly the first IDLE cycle after a command; a new request MAY be accepted in that same cycle.
REQ-025 s and r SHALL never both be 1 in any cycle.
REQ-026 s and r SHALL be 0 in IDLE and GUARD.
REQ-027 req_valid while busy SHALL be ignored. Commands are not queued; the requester holds req_valid until it is accepted.
REQ-028 req_op SHALL be sampled only at acceptance; changes during PULSE or GUARD SHALL have no effect.
REQ-029 Back-to-back commands SHALL have no idle gap beyond the done cycle: period = PULSE_W + GUARD_W + 1 cycles.

Reset
REQ-030 While rst is high, and immediately on its assertion including mid-PULSE or mid-GUARD, the block SHALL force: state=IDLE, s=0, r=0, en=0, q_exp=0, busy=0, done=0, req_ready=0, op_cnt=0.
REQ-031 The first rising edge after rst deasserts SHALL see req_ready=1. No command SHALL be accepted while rst is high.

Configuration
REQ-032 When macro SR_DRV_COUNT_EN is defined, op_cnt SHALL increment by 1 in the done cycle and saturate at 255.
REQ-033 When SR_DRV_COUNT_EN is not defined, op_cnt SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-034 Set command: PULSE_W=4, GUARD_W=2; reset, then set accepted at edge k.
- Required: s=1, en=1 for cycles k+1..k+4; s=r=0 for k+5..k+6; done=1 and req_ready=1 at k+7; q_exp=1 from k+1.
REQ-035 Toggle sequence: reset, then toggle, toggle, toggle.
- Required: q_exp goes 1, 0, 1; drive goes s, then r, then s, each held 4 cycles; op_cnt=3 with SR_DRV_COUNT_EN.
REQ-036 Disable: set, then disable.
- Required: en=0 and s=r=0 for 4 cycles and remaining 0 afterwards; q_exp=0; a following clear restores en=1.
REQ-037 Busy and reset handling: req_valid held with op=10 during the 2nd PULSE cycle of a clear.
- Required: not accepted until the done cycle.
- Then assert rst in the 2nd cycle of the new set pulse. Required: s, en, q_exp and busy all 0 within the same cycle.
REQ-038 Random stress: 1000 random commands with random req_valid gaps, GUARD_W=0.
- Required: s&r never 1; q_exp matches a reference SR-latch model driven by s, r, en at every cycle.
